// File: rtl/life_engine.sv
// Game-of-Life (B3/S23) generation engine: streams the board through a 3-row window
// from a 1-cycle-latency RAM and writes each evolved row back in place.
module life_engine #(
  parameter int COLS = 20,
  parameter int ROWS = 16,
  parameter int AW   = 4,
  parameter int WRAP = 0
) (
  input  logic            clk_50MHz_i,
  input  logic            rst_sync_la_i,
  input  logic            next_i,
  input  logic [COLS-1:0] row_from_ram_i,
  output logic [COLS-1:0] row_to_ram_o,
  output logic [AW-1:0]   ram_addr_o,
  output logic            ram_we_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [15:0]     gen_count_o
);

  typedef enum logic [2:0] {
    IDLE, FILL_RD, FILL_CAP, WR, RD, CAP, INJ, DONE
  } state_t;

  localparam logic [AW-1:0] LAST_ROW = AW'(ROWS - 1);

  state_t          r_state;
  logic [AW-1:0]   r_row;
  logic [AW-1:0]   r_addr;
  logic [1:0]      r_fillLeft;
  logic [COLS-1:0] r_up;
  logic [COLS-1:0] r_mid;
  logic [COLS-1:0] r_dn;
  logic [COLS-1:0] r_sav0;
  logic            r_we;
  logic            r_busy;
  logic            r_done;
  logic [15:0]     r_genCount;

  logic [COLS+1:0] w_upX;
  logic [COLS+1:0] w_midX;
  logic [COLS+1:0] w_dnX;
  logic [COLS-1:0] w_newRow;
  logic [3:0]      w_count;

  // Bit 0 of each extended row is column -1, bit COLS+1 is column COLS.
  assign w_upX  = {(WRAP != 0) ? r_up[0]  : 1'b0, r_up,  (WRAP != 0) ? r_up[COLS-1]  : 1'b0};
  assign w_midX = {(WRAP != 0) ? r_mid[0] : 1'b0, r_mid, (WRAP != 0) ? r_mid[COLS-1] : 1'b0};
  assign w_dnX  = {(WRAP != 0) ? r_dn[0]  : 1'b0, r_dn,  (WRAP != 0) ? r_dn[COLS-1]  : 1'b0};

  always_comb begin
    w_newRow = '0;
    w_count  = '0;
    for (int c = 0; c < COLS; c++) begin
      w_count = 4'(w_upX[c]) + 4'(w_upX[c+1]) + 4'(w_upX[c+2])
              + 4'(w_midX[c]) + 4'(w_midX[c+2])
              + 4'(w_dnX[c]) + 4'(w_dnX[c+1]) + 4'(w_dnX[c+2]);
      w_newRow[c] = (w_count == 4'd3) || (r_mid[c] && (w_count == 4'd2));
    end
  end

  assign row_to_ram_o = r_we ? w_newRow : '0;
  assign ram_addr_o   = r_addr;
  assign ram_we_o     = r_we;
  assign busy_o       = r_busy;
  assign done_o       = r_done;
  assign gen_count_o  = r_genCount;

  always_ff @(posedge clk_50MHz_i) begin
    if (!rst_sync_la_i) begin
      r_state    <= IDLE;
      r_row      <= '0;
      r_addr     <= '0;
      r_fillLeft <= '0;
      r_up       <= '0;
      r_mid      <= '0;
      r_dn       <= '0;
      r_sav0     <= '0;
      r_we       <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_genCount <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (next_i) begin
            r_busy     <= 1'b1;
            r_row      <= '0;
            r_fillLeft <= (WRAP != 0) ? 2'd2 : 2'd1;
            r_addr     <= (WRAP != 0) ? LAST_ROW : '0;
            if (WRAP == 0) begin
              r_up  <= '0;
              r_mid <= '0;
              r_dn  <= '0;
            end
            r_state <= FILL_RD;
          end
        end
        FILL_RD: r_state <= FILL_CAP;
        FILL_CAP: begin
          r_up  <= r_mid;
          r_mid <= r_dn;
          r_dn  <= row_from_ram_i;
          if ((WRAP != 0) && (r_addr == '0)) r_sav0 <= row_from_ram_i;
          if (r_fillLeft == 2'd0) begin
            r_addr  <= r_row;
            r_we    <= 1'b1;
            r_state <= WR;
          end else begin
            r_fillLeft <= r_fillLeft - 2'd1;
            r_addr     <= (r_addr == LAST_ROW) ? '0 : r_addr + AW'(1);
            r_state    <= FILL_RD;
          end
        end
        WR: begin
          r_we <= 1'b0;
          if (r_row == LAST_ROW) begin
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_genCount <= r_genCount + 16'd1;
            r_state    <= DONE;
          end else if (int'(r_row) + 2 < ROWS) begin
            r_addr  <= r_row + AW'(2);
            r_state <= RD;
          end else begin
            r_state <= INJ;
          end
        end
        RD: r_state <= CAP;
        CAP: begin
          r_up    <= r_mid;
          r_mid   <= r_dn;
          r_dn    <= row_from_ram_i;
          r_row   <= r_row + AW'(1);
          r_addr  <= r_row + AW'(1);
          r_we    <= 1'b1;
          r_state <= WR;
        end
        // Last row's lower neighbour is the saved original row 0 (torus) or dead space.
        INJ: begin
          r_up    <= r_mid;
          r_mid   <= r_dn;
          r_dn    <= (WRAP != 0) ? r_sav0 : '0;
          r_row   <= r_row + AW'(1);
          r_addr  <= r_row + AW'(1);
          r_we    <= 1'b1;
          r_state <= WR;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_life_engine.sv
// Directed self-checking bench for life_engine: one bounded-edge instance (WRAP=0) and
// one toroidal instance (WRAP=1), each backed by a behavioural synchronous RAM.
module tb_life_engine;

  logic clk;
  logic rstN;

  logic        next0, next1;
  logic [19:0] rowIn0, rowIn1, rowOut0, rowOut1;
  logic [3:0]  addr0, addr1;
  logic        we0, we1, busy0, busy1, done0, done1;
  logic [15:0] gen0, gen1;

  logic [19:0] mem0 [0:15];
  logic [19:0] mem1 [0:15];
  logic        ldEn0, ldEn1;
  logic [3:0]  ldAddr;
  logic [19:0] ldData;

  logic [19:0] initB [0:15];
  logic [19:0] expB  [0:15];

  int vectors = 0;
  int miscompares = 0;

  // Per-run observations collected by applyStimulus
  int busyCycles, writes, doneCnt, wrExp;
  bit addrOk;

  bit         sel;
  logic       mBusy, mWe, mDone;
  logic [3:0] mAddr;

  assign mBusy = sel ? busy1 : busy0;
  assign mWe   = sel ? we1   : we0;
  assign mDone = sel ? done1 : done0;
  assign mAddr = sel ? addr1 : addr0;

  life_engine #(.COLS(20), .ROWS(16), .AW(4), .WRAP(0)) u0 (
    .clk_50MHz_i   (clk),
    .rst_sync_la_i (rstN),
    .next_i        (next0),
    .row_from_ram_i(rowIn0),
    .row_to_ram_o  (rowOut0),
    .ram_addr_o    (addr0),
    .ram_we_o      (we0),
    .busy_o        (busy0),
    .done_o        (done0),
    .gen_count_o   (gen0)
  );

  life_engine #(.COLS(20), .ROWS(16), .AW(4), .WRAP(1)) u1 (
    .clk_50MHz_i   (clk),
    .rst_sync_la_i (rstN),
    .next_i        (next1),
    .row_from_ram_i(rowIn1),
    .row_to_ram_o  (rowOut1),
    .ram_addr_o    (addr1),
    .ram_we_o      (we1),
    .busy_o        (busy1),
    .done_o        (done1),
    .gen_count_o   (gen1)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Synchronous RAMs with one cycle read latency; the bench back-door port only loads while the DUT is idle
  always @(posedge clk) begin
    if (we0) mem0[addr0] <= rowOut0;
    else if (ldEn0) mem0[ldAddr] <= ldData;
    rowIn0 <= mem0[addr0];
    if (we1) mem1[addr1] <= rowOut1;
    else if (ldEn1) mem1[ldAddr] <= ldData;
    rowIn1 <= mem1[addr1];
  end

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clearBoards();
    for (int r = 0; r < 16; r++) begin
      initB[r] = '0;
      expB[r]  = '0;
    end
  endtask

  task automatic loadBoard(input bit inst);
    for (int r = 0; r < 16; r++) begin
      @(negedge clk);
      ldAddr = 4'(r);
      ldData = initB[r];
      ldEn0  = !inst;
      ldEn1  = inst;
    end
    @(negedge clk);
    ldEn0 = 1'b0;
    ldEn1 = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clk);
    rstN = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
  endtask

  task automatic checkBoard(input bit inst, input string tag);
    for (int r = 0; r < 16; r++)
      checkOutput($sformatf("%s row%0d", tag, r), 32'(inst ? mem1[r] : mem0[r]), 32'(expB[r]));
  endtask

  // Starts one generation and watches a fixed 70-cycle window; optional next pulse / reset at busy cycle k+1
  task automatic applyStimulus(input bit inst, input int pulseAt, input int resetAt);
    sel = inst;
    busyCycles = 0;
    writes = 0;
    doneCnt = 0;
    wrExp = 0;
    addrOk = 1'b1;
    @(negedge clk);
    if (inst) next1 = 1'b1; else next0 = 1'b1;
    @(negedge clk);
    next0 = 1'b0;
    next1 = 1'b0;
    for (int k = 0; k < 70; k++) begin
      if (mBusy) busyCycles++;
      if (mWe) begin
        if (mAddr !== 4'(wrExp)) addrOk = 1'b0;
        wrExp++;
        writes++;
      end
      if (mDone) doneCnt++;
      if (k == pulseAt) begin
        if (inst) next1 = 1'b1; else next0 = 1'b1;
      end else begin
        next0 = 1'b0;
        next1 = 1'b0;
      end
      if (k == resetAt) begin
        rstN = 1'b0;
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rstN   = 1'b0;
    next0  = 1'b0;
    next1  = 1'b0;
    ldEn0  = 1'b0;
    ldEn1  = 1'b0;
    ldAddr = '0;
    ldData = '0;
    sel    = 1'b0;
    repeat (2) @(negedge clk);

    checkOutput("reset busy0", 32'(busy0), 32'd0);
    checkOutput("reset done0", 32'(done0), 32'd0);
    checkOutput("reset we0", 32'(we0), 32'd0);
    checkOutput("reset addr0", 32'(addr0), 32'd0);
    checkOutput("reset row0", 32'(rowOut0), 32'd0);
    checkOutput("reset gen0", 32'(gen0), 32'd0);
    checkOutput("reset busy1", 32'(busy1), 32'd0);
    checkOutput("reset gen1", 32'(gen1), 32'd0);
    rstN = 1'b1;

    // Vertical blinker in rows 7..9, column 5 flips to horizontal in row 8
    clearBoards();
    initB[7] = 20'h00020; initB[8] = 20'h00020; initB[9] = 20'h00020;
    expB[8]  = 20'h00070;
    loadBoard(1'b0);
    applyStimulus(1'b0, -1, -1);
    checkBoard(1'b0, "blinker");
    checkOutput("blinker writes", 32'(writes), 32'd16);
    checkOutput("blinker addrseq", 32'(addrOk), 32'd1);
    checkOutput("blinker done", 32'(doneCnt), 32'd1);
    checkOutput("blinker busy", 32'(busyCycles), 32'd49);
    checkOutput("blinker gen", 32'(gen0), 32'd1);

    // Block still life must survive unchanged
    clearBoards();
    initB[3] = 20'h00018; initB[4] = 20'h00018;
    expB[3]  = 20'h00018; expB[4]  = 20'h00018;
    loadBoard(1'b0);
    doReset();
    applyStimulus(1'b0, -1, -1);
    checkBoard(1'b0, "block");
    checkOutput("block gen", 32'(gen0), 32'd1);
    checkOutput("block done", 32'(doneCnt), 32'd1);

    // Torus: blinker through rows 15,0,1 at column 0 becomes row 0 columns 19,0,1
    clearBoards();
    initB[15] = 20'h00001; initB[0] = 20'h00001; initB[1] = 20'h00001;
    expB[0]   = 20'h80003;
    loadBoard(1'b1);
    applyStimulus(1'b1, -1, -1);
    checkBoard(1'b1, "wrap");
    checkOutput("wrap busy", 32'(busyCycles), 32'd51);
    checkOutput("wrap writes", 32'(writes), 32'd16);
    checkOutput("wrap done", 32'(doneCnt), 32'd1);
    checkOutput("wrap gen", 32'(gen1), 32'd1);

    // Without wrap rows 15/0/1 are not neighbours: every live cell has at most one
    // live neighbour and no dead cell reaches three, so the board empties
    clearBoards();
    initB[15] = 20'h00001; initB[0] = 20'h00001; initB[1] = 20'h00001;
    loadBoard(1'b0);
    doReset();
    applyStimulus(1'b0, -1, -1);
    checkBoard(1'b0, "edge");
    checkOutput("edge busy", 32'(busyCycles), 32'd49);
    checkOutput("edge addrseq", 32'(addrOk), 32'd1);

    // next_i pulsed mid-generation must be dropped
    clearBoards();
    initB[7] = 20'h00020; initB[8] = 20'h00020; initB[9] = 20'h00020;
    expB[8]  = 20'h00070;
    loadBoard(1'b0);
    doReset();
    applyStimulus(1'b0, 9, -1);
    checkOutput("ignore done", 32'(doneCnt), 32'd1);
    checkOutput("ignore busy", 32'(busyCycles), 32'd49);
    checkOutput("ignore gen", 32'(gen0), 32'd1);
    checkOutput("ignore row8", 32'(mem0[8]), 32'h00070);

    // Reset at busy cycle 20 aborts; only all-zero rows had been rewritten, so a rerun is clean
    clearBoards();
    initB[7] = 20'h00020; initB[8] = 20'h00020; initB[9] = 20'h00020;
    expB[8]  = 20'h00070;
    loadBoard(1'b0);
    doReset();
    applyStimulus(1'b0, -1, 19);
    checkOutput("abort busy", 32'(busy0), 32'd0);
    checkOutput("abort we", 32'(we0), 32'd0);
    checkOutput("abort gen", 32'(gen0), 32'd0);
    checkOutput("abort done", 32'(done0), 32'd0);
    rstN = 1'b1;
    applyStimulus(1'b0, -1, -1);
    checkBoard(1'b0, "rerun");
    checkOutput("rerun gen", 32'(gen0), 32'd1);
    checkOutput("rerun done", 32'(doneCnt), 32'd1);

    // Counter wrap: preset to 0xFFFF, one more generation rolls to 0 and the blinker flips back
    force u0.r_genCount = 16'hFFFF;
    @(negedge clk);
    release u0.r_genCount;
    @(negedge clk);
    clearBoards();
    expB[7] = 20'h00020; expB[8] = 20'h00020; expB[9] = 20'h00020;
    applyStimulus(1'b0, -1, -1);
    checkOutput("genwrap gen", 32'(gen0), 32'd0);
    checkOutput("genwrap done", 32'(doneCnt), 32'd1);
    checkBoard(1'b0, "genwrap");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
